npc_ctrl: RTL

Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, decode, execute, memory access and writeback. It drives the write enables for the PC register, instruction register and register file, and runs the valid/ack handshakes with the instruction fetch unit and the load/store unit. It sits beside the PC, decoder and ALU datapath. It owns no datapath state itself, only the control flow and the halt condition.

---
 rtl/npc_ctrl_pkg.sv | 40 ++++
 rtl/npc_perf_cnt.sv | 26 ++
 rtl/npc_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle control sequencer:
// state encoding, RV32I major opcodes and the EBREAK instruction word.
package npc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK = 32'h00100073;

    function automatic logic op_legal(input logic [6:0] opc);
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic inst_is_ebreak(input logic [31:0] inst);
        return inst == EBREAK;
    endfunction

endpackage

// File: rtl/npc_perf_cnt.sv
// Pair of free-running performance counters with independent increment
// enables; wraps modulo 2^CNT_W. Used by npc_ctrl under NPC_CTRL_PERF_EN.
module npc_perf_cnt
    import npc_ctrl_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_a,
    input  logic             inc_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (inc_a) cnt_a <= cnt_a + 1'b1;
            if (inc_b) cnt_b <= cnt_b + 1'b1;
        end
    end

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core.
// Optional mcycle/minstret counters when NPC_CTRL_PERF_EN is defined.
module npc_ctrl
    import npc_ctrl_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req,
    input  logic             ifu_ack,
    input  logic [6:0]       op,
    input  logic             is_ebreak,
    output logic             lsu_req,
    output logic             lsu_we,
    input  logic             lsu_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halt,
    output logic             illegal,
    output logic [2:0]       state
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] mcycle,
    output logic [CNT_W-1:0] minstret
`endif
);

    state_t state_q, state_d;
    logic   illegal_q;
    logic   illegal_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (illegal_set) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        ifu_req     = 1'b0;
        ir_we       = 1'b0;
        lsu_req     = 1'b0;
        lsu_we      = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                ifu_req = 1'b1;
                if (ifu_ack) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // EBREAK is a clean stop; any other SYSTEM encoding is unsupported
                if (is_ebreak) begin
                    state_d = ST_HALT;
                end else if (!op_legal(op) || op == OP_SYSTEM) begin
                    state_d     = ST_HALT;
                    illegal_set = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = (op == OP_LOAD || op == OP_STORE) ? ST_MEM : ST_WB;
            ST_MEM: begin
                lsu_req = 1'b1;
                lsu_we  = (op == OP_STORE);
                if (lsu_ack) state_d = ST_WB;
            end
            ST_WB: begin
                pc_we   = 1'b1;
                rf_we   = !(op == OP_STORE || op == OP_BRANCH);
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign halt    = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign state   = state_q;

`ifdef NPC_CTRL_PERF_EN
    npc_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_a (1'b1),
        .inc_b (state_q == ST_WB),
        .cnt_a (mcycle),
        .cnt_b (minstret)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
